// File: rtl/pr_ready_scoreboard.sv
// Physical-register ready scoreboard with writeback bypass and branch checkpoints.
// Latency: pr_status/ckpt_* update one cycle after inputs; rd_ready is combinational.
// Backpressure: none; a take while full is dropped unless a release frees the slot that same cycle.
module pr_ready_scoreboard #(
  parameter int PR_NUM        = 65,
  parameter int PR_W          = 7,
  parameter int RN_PORTS      = 4,
  parameter int WB_PORTS      = 4,
  parameter int RD_PORTS      = 8,
  parameter int CKPT_NUM      = 4,
  parameter int CKPT_W        = 2,
  parameter bit ZERO_PR_READY = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_all,
  input  logic [RN_PORTS-1:0]      rn_en,
  input  logic [RN_PORTS*PR_W-1:0] rn_pr,
  input  logic [WB_PORTS-1:0]      wb_en,
  input  logic [WB_PORTS*PR_W-1:0] wb_pr,
  input  logic [RD_PORTS*PR_W-1:0] rd_pr,
  output logic [RD_PORTS-1:0]      rd_ready,
  input  logic                     ckpt_take,
  input  logic                     ckpt_release,
  input  logic                     recover_en,
  input  logic [CKPT_W-1:0]        recover_id,
  output logic [CKPT_W-1:0]        ckpt_new_id,
  output logic [CKPT_W:0]          ckpt_count,
  output logic                     ckpt_full,
  output logic                     ckpt_empty,
  output logic [PR_NUM-1:0]        pr_status
);

  logic [PR_NUM-1:0] ren_mask;
  logic [PR_NUM-1:0] wb_mask;
  logic [PR_NUM-1:0] nxt;
  logic [PR_NUM-1:0] rec_vec;
  logic [PR_NUM-1:0] snap [CKPT_NUM];

  logic [CKPT_W-1:0] head;
  logic [CKPT_W-1:0] tail;
  logic [CKPT_W:0]   count;
  logic [CKPT_W-1:0] rec_off;
  logic              rec_ok;
  logic              rel_ok;
  logic              take_ok;

  // Decode rename/writeback ports into per-PR masks; out-of-range indices never match.
  always_comb begin
    ren_mask = '0;
    wb_mask  = '0;
    for (int p = 0; p < PR_NUM; p++) begin
      for (int i = 0; i < RN_PORTS; i++) begin
        if (rn_en[i] && (rn_pr[i*PR_W +: PR_W] == PR_W'(p))) ren_mask[p] = 1'b1;
      end
      for (int k = 0; k < WB_PORTS; k++) begin
        if (wb_en[k] && (wb_pr[k*PR_W +: PR_W] == PR_W'(p))) wb_mask[p] = 1'b1;
      end
    end
  end

  // Normal next-state vector: rename clears first, writeback sets win on collision.
  always_comb begin
    nxt = (pr_status & ~ren_mask) | wb_mask;
    if (ZERO_PR_READY) nxt[0] = 1'b1;
  end

  // Source lookups see the registered vector plus this cycle's writebacks, never renames.
  always_comb begin
    rd_ready = '0;
    for (int j = 0; j < RD_PORTS; j++) begin
      for (int p = 0; p < PR_NUM; p++) begin
        if (rd_pr[j*PR_W +: PR_W] == PR_W'(p)) rd_ready[j] = pr_status[p] | wb_mask[p];
      end
    end
  end

  // Restored vector: chosen snapshot with same-cycle completions folded in.
  always_comb begin
    rec_vec = snap[recover_id] | wb_mask;
    if (ZERO_PR_READY) rec_vec[0] = 1'b1;
  end

  assign ckpt_new_id = tail;
  assign ckpt_count  = count;
  assign ckpt_full   = (count == (CKPT_W+1)'(CKPT_NUM));
  assign ckpt_empty  = (count == '0);

  // A checkpoint id is live when its distance from head is below the live count.
  assign rec_off = recover_id - head;
  assign rec_ok  = recover_en && ({1'b0, rec_off} < count);
  assign rel_ok  = ckpt_release && !ckpt_empty;
  // When full, a simultaneous release frees the head slot, so the take can reuse it.
  assign take_ok = ckpt_take && !rec_ok && (!ckpt_full || rel_ok);

  // Ready vector and checkpoint FIFO pointers; flush beats recovery beats normal update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pr_status <= '1;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else if (flush_all) begin
      pr_status <= '1;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else if (rec_ok) begin
      pr_status <= rec_vec;
      tail      <= recover_id + CKPT_W'(1);
      head      <= head + CKPT_W'(rel_ok);
      count     <= (CKPT_W+1)'(rec_off) + (CKPT_W+1)'(1) - (CKPT_W+1)'(rel_ok);
    end else begin
      pr_status <= nxt;
      tail      <= tail + CKPT_W'(take_ok);
      head      <= head + CKPT_W'(rel_ok);
      count     <= count + (CKPT_W+1)'(take_ok) - (CKPT_W+1)'(rel_ok);
    end
  end

  // Snapshots accumulate every writeback so older completions survive a restore.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CKPT_NUM; i++) begin
      if (take_ok && !flush_all && (tail == CKPT_W'(i))) snap[i] <= nxt;
      else                                               snap[i] <= snap[i] | wb_mask;
    end
  end

endmodule

// File: tb/tb_pr_ready_scoreboard.sv
module tb_pr_ready_scoreboard;
  localparam int PR_NUM   = 65;
  localparam int PR_W     = 7;
  localparam int RN_PORTS = 4;
  localparam int WB_PORTS = 4;
  localparam int RD_PORTS = 8;
  localparam int CKPT_NUM = 4;
  localparam int CKPT_W   = 2;
  localparam logic [PR_NUM-1:0] ALL1 = '1;

  logic                     clk;
  logic                     rst;
  logic                     flush_all;
  logic [RN_PORTS-1:0]      rn_en;
  logic [RN_PORTS*PR_W-1:0] rn_pr;
  logic [WB_PORTS-1:0]      wb_en;
  logic [WB_PORTS*PR_W-1:0] wb_pr;
  logic [RD_PORTS*PR_W-1:0] rd_pr;
  logic [RD_PORTS-1:0]      rd_ready;
  logic                     ckpt_take;
  logic                     ckpt_release;
  logic                     recover_en;
  logic [CKPT_W-1:0]        recover_id;
  logic [CKPT_W-1:0]        ckpt_new_id;
  logic [CKPT_W:0]          ckpt_count;
  logic                     ckpt_full;
  logic                     ckpt_empty;
  logic [PR_NUM-1:0]        pr_status;

  int checks = 0;
  int errors = 0;
  logic [PR_NUM-1:0] exp_v;

  pr_ready_scoreboard #(
    .PR_NUM(PR_NUM), .PR_W(PR_W), .RN_PORTS(RN_PORTS), .WB_PORTS(WB_PORTS),
    .RD_PORTS(RD_PORTS), .CKPT_NUM(CKPT_NUM), .CKPT_W(CKPT_W), .ZERO_PR_READY(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .flush_all(flush_all),
    .rn_en(rn_en), .rn_pr(rn_pr), .wb_en(wb_en), .wb_pr(wb_pr),
    .rd_pr(rd_pr), .rd_ready(rd_ready),
    .ckpt_take(ckpt_take), .ckpt_release(ckpt_release),
    .recover_en(recover_en), .recover_id(recover_id),
    .ckpt_new_id(ckpt_new_id), .ckpt_count(ckpt_count),
    .ckpt_full(ckpt_full), .ckpt_empty(ckpt_empty), .pr_status(pr_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    flush_all = 0; rn_en = '0; rn_pr = '0; wb_en = '0; wb_pr = '0; rd_pr = '0;
    ckpt_take = 0; ckpt_release = 0; recover_en = 0; recover_id = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #3;
    checks++; if (pr_status !== ALL1) begin errors++; $display("FAIL reset_status got %h exp %h", pr_status, ALL1); end
    checks++; if (ckpt_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", ckpt_count); end
    checks++; if (ckpt_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", ckpt_empty); end
    checks++; if (ckpt_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", ckpt_full); end
    checks++; if (ckpt_new_id !== 2'd0) begin errors++; $display("FAIL reset_new_id got %0d exp 0", ckpt_new_id); end
    step();
    rst = 0;
    step();
  endtask

  task automatic test_rename();
    rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd5;
    rn_en[1] = 1; rn_pr[1*PR_W +: PR_W] = 7'd9;
    step(); idle();
    exp_v = ALL1; exp_v[5] = 1'b0; exp_v[9] = 1'b0;
    checks++; if (pr_status !== exp_v) begin errors++; $display("FAIL rename_5_9 got %h exp %h", pr_status, exp_v); end
    wb_en[2] = 1; wb_pr[2*PR_W +: PR_W] = 7'd5;
    wb_en[3] = 1; wb_pr[3*PR_W +: PR_W] = 7'd9;
    step(); idle();
    checks++; if (pr_status !== ALL1) begin errors++; $display("FAIL wb_5_9 got %h exp %h", pr_status, ALL1); end
  endtask

  task automatic test_bypass();
    rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd12;
    step(); idle();
    checks++; if (pr_status[12] !== 1'b0) begin errors++; $display("FAIL rename_12 got %b exp 0", pr_status[12]); end
    step(); step();
    wb_en[0] = 1; wb_pr[0*PR_W +: PR_W] = 7'd12;
    rn_en[1] = 1; rn_pr[1*PR_W +: PR_W] = 7'd21;
    rd_pr[0*PR_W +: PR_W] = 7'd12;
    rd_pr[1*PR_W +: PR_W] = 7'd100;
    rd_pr[2*PR_W +: PR_W] = 7'd21;
    #1;
    checks++; if (rd_ready[0] !== 1'b1) begin errors++; $display("FAIL bypass_12 got %b exp 1", rd_ready[0]); end
    checks++; if (rd_ready[1] !== 1'b0) begin errors++; $display("FAIL oob_read got %b exp 0", rd_ready[1]); end
    checks++; if (rd_ready[2] !== 1'b1) begin errors++; $display("FAIL rename_no_rd_effect got %b exp 1", rd_ready[2]); end
    checks++; if (pr_status[12] !== 1'b0) begin errors++; $display("FAIL status_12_pre got %b exp 0", pr_status[12]); end
    step(); idle();
    checks++; if (pr_status[12] !== 1'b1) begin errors++; $display("FAIL status_12_post got %b exp 1", pr_status[12]); end
    checks++; if (pr_status[21] !== 1'b0) begin errors++; $display("FAIL status_21 got %b exp 0", pr_status[21]); end
    rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd20;
    wb_en[1] = 1; wb_pr[1*PR_W +: PR_W] = 7'd20;
    wb_en[2] = 1; wb_pr[2*PR_W +: PR_W] = 7'd21;
    rn_en[3] = 1; rn_pr[3*PR_W +: PR_W] = 7'd120;
    step(); idle();
    checks++; if (pr_status !== ALL1) begin errors++; $display("FAIL rn_wb_collide_20 got %h exp %h", pr_status, ALL1); end
  endtask

  task automatic test_ckpt_recover();
    rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd30; ckpt_take = 1;
    step(); idle();
    checks++; if (ckpt_count !== 3'd1) begin errors++; $display("FAIL take_count got %0d exp 1", ckpt_count); end
    checks++; if (ckpt_new_id !== 2'd1) begin errors++; $display("FAIL take_new_id got %0d exp 1", ckpt_new_id); end
    rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd31;
    step(); idle();
    wb_en[0] = 1; wb_pr[0*PR_W +: PR_W] = 7'd30;
    step(); idle();
    exp_v = ALL1; exp_v[31] = 1'b0;
    checks++; if (pr_status !== exp_v) begin errors++; $display("FAIL pre_recover got %h exp %h", pr_status, exp_v); end
    recover_en = 1; recover_id = 2'd0;
    step(); idle();
    checks++; if (pr_status !== ALL1) begin errors++; $display("FAIL recover0_status got %h exp %h", pr_status, ALL1); end
    checks++; if (ckpt_count !== 3'd1) begin errors++; $display("FAIL recover0_count got %0d exp 1", ckpt_count); end
    checks++; if (ckpt_new_id !== 2'd1) begin errors++; $display("FAIL recover0_new_id got %0d exp 1", ckpt_new_id); end
    ckpt_release = 1;
    step(); idle();
    checks++; if (ckpt_empty !== 1'b1) begin errors++; $display("FAIL release_empty got %b exp 1", ckpt_empty); end
  endtask

  task automatic test_full();
    ckpt_take = 1;
    step(); step(); step(); step(); idle();
    checks++; if (ckpt_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", ckpt_full); end
    checks++; if (ckpt_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", ckpt_count); end
    ckpt_take = 1;
    step(); idle();
    checks++; if (ckpt_count !== 3'd4) begin errors++; $display("FAIL drop_count got %0d exp 4", ckpt_count); end
    checks++; if (ckpt_new_id !== 2'd1) begin errors++; $display("FAIL drop_new_id got %0d exp 1", ckpt_new_id); end
    ckpt_take = 1; ckpt_release = 1;
    step(); idle();
    checks++; if (ckpt_count !== 3'd4) begin errors++; $display("FAIL take_rel_count got %0d exp 4", ckpt_count); end
    checks++; if (ckpt_new_id !== 2'd2) begin errors++; $display("FAIL take_rel_new_id got %0d exp 2", ckpt_new_id); end
    ckpt_release = 1;
    step(); step(); step(); step(); idle();
    checks++; if (ckpt_count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", ckpt_count); end
  endtask

  task automatic test_recover_live();
    rst = 1; step(); rst = 0;
    ckpt_take = 1; rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd60;
    step(); rn_en = '0;
    step(); step();
    rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd61;
    step(); idle();
    ckpt_release = 1;
    step(); idle();
    checks++; if (ckpt_count !== 3'd3) begin errors++; $display("FAIL live3_count got %0d exp 3", ckpt_count); end
    recover_en = 1; recover_id = 2'd2;
    step(); idle();
    exp_v = ALL1; exp_v[60] = 1'b0;
    checks++; if (pr_status !== exp_v) begin errors++; $display("FAIL recover2_status got %h exp %h", pr_status, exp_v); end
    checks++; if (ckpt_count !== 3'd2) begin errors++; $display("FAIL recover2_count got %0d exp 2", ckpt_count); end
    checks++; if (ckpt_new_id !== 2'd3) begin errors++; $display("FAIL recover2_new_id got %0d exp 3", ckpt_new_id); end
    recover_en = 1; recover_id = 2'd0;
    rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd50;
    step(); idle();
    exp_v[50] = 1'b0;
    checks++; if (pr_status !== exp_v) begin errors++; $display("FAIL nonlive_status got %h exp %h", pr_status, exp_v); end
    checks++; if (ckpt_count !== 3'd2) begin errors++; $display("FAIL nonlive_count got %0d exp 2", ckpt_count); end
    ckpt_take = 1;
    step(); idle();
    checks++; if (ckpt_new_id !== 2'd0) begin errors++; $display("FAIL take_after_rec_id got %0d exp 0", ckpt_new_id); end
    checks++; if (ckpt_count !== 3'd3) begin errors++; $display("FAIL take_after_rec_count got %0d exp 3", ckpt_count); end
  endtask

  task automatic test_flush();
    flush_all = 1; ckpt_take = 1; recover_en = 1; recover_id = 2'd1;
    rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd40;
    step(); idle();
    checks++; if (pr_status !== ALL1) begin errors++; $display("FAIL flush_status got %h exp %h", pr_status, ALL1); end
    checks++; if (ckpt_count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", ckpt_count); end
    checks++; if (ckpt_new_id !== 2'd0) begin errors++; $display("FAIL flush_new_id got %0d exp 0", ckpt_new_id); end
    ckpt_release = 1;
    step(); idle();
    checks++; if (ckpt_count !== 3'd0) begin errors++; $display("FAIL rel_empty_count got %0d exp 0", ckpt_count); end
    checks++; if (ckpt_empty !== 1'b1) begin errors++; $display("FAIL rel_empty_flag got %b exp 1", ckpt_empty); end
  endtask

  task automatic test_async_reset();
    ckpt_take = 1; rn_en[0] = 1; rn_pr[0*PR_W +: PR_W] = 7'd7;
    step(); step();
    checks++; if (ckpt_count !== 3'd2) begin errors++; $display("FAIL burst_count got %0d exp 2", ckpt_count); end
    #2;
    rst = 1;
    #1;
    checks++; if (pr_status !== ALL1) begin errors++; $display("FAIL arst_status got %h exp %h", pr_status, ALL1); end
    checks++; if (ckpt_count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", ckpt_count); end
    checks++; if (ckpt_new_id !== 2'd0) begin errors++; $display("FAIL arst_new_id got %0d exp 0", ckpt_new_id); end
    checks++; if (ckpt_empty !== 1'b1 || ckpt_full !== 1'b0) begin errors++; $display("FAIL arst_flags got empty %b full %b exp 1 0", ckpt_empty, ckpt_full); end
    idle();
    step();
    rst = 0;
  endtask

  task automatic test_zero_pr();
    rn_en[2] = 1; rn_pr[2*PR_W +: PR_W] = 7'd0;
    rd_pr[5*PR_W +: PR_W] = 7'd0;
    #1;
    checks++; if (rd_ready[5] !== 1'b1) begin errors++; $display("FAIL zero_pr_rd got %b exp 1", rd_ready[5]); end
    step(); idle();
    checks++; if (pr_status !== ALL1) begin errors++; $display("FAIL zero_pr_status got %h exp %h", pr_status, ALL1); end
  endtask

  initial begin
    test_reset();
    test_rename();
    test_bypass();
    test_ckpt_recover();
    test_full();
    test_recover_live();
    test_flush();
    test_async_reset();
    test_zero_pr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pr_ready_scoreboard.md
# pr_ready_scoreboard

Parametrised physical-register ready scoreboard for the rename/issue stage, next generation of the single-vector PR status table. Tracks one ready bit per physical register:
- cleared by rename allocation, set by execution-unit writeback;
- issue-queue source lookups get a same-cycle writeback bypass;
- branch checkpoints restore ready state on misprediction instead of marking every register ready.

## Interface
- PR_NUM, 65: number of physical registers.
- PR_W, 7: PR index width; PR_W ≥ clog2(PR_NUM).
- RN_PORTS, 4: rename destination ports.
- WB_PORTS, 4: writeback ports.
- RD_PORTS, 8: source-lookup ports.
- CKPT_NUM, 4: checkpoint slots; power of two.
- CKPT_W, 2: log2(CKPT_NUM).
- ZERO_PR_READY, 1: when 1, PR 0 is hardwired ready.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_all  in  1  full pipeline flush.
- rn_en  in  RN_PORTS  per-port allocation valid.
- rn_pr  in  RN_PORTS*PR_W  allocated PRs; port i at [i*PR_W +: PR_W].
- wb_en  in  WB_PORTS  per-port writeback valid.
- wb_pr  in  WB_PORTS*PR_W  written-back PRs.
- rd_pr  in  RD_PORTS*PR_W  source PRs to look up.
- rd_ready  out  RD_PORTS  combinational ready per lookup.
- ckpt_take  in  1  snapshot request.
- ckpt_release  in  1  free oldest checkpoint (branch retired).
- recover_en  in  1  restore from checkpoint.
- recover_id  in  CKPT_W  checkpoint to restore.
- ckpt_new_id  out  CKPT_W  slot the next accepted take uses (tail).
- ckpt_count  out  CKPT_W+1  live checkpoints.
- ckpt_full, ckpt_empty  out  1  count == CKPT_NUM / count == 0.
- pr_status  out  PR_NUM  registered ready vector.

## Operation
- Next-state ready vector (nxt):
  - start from pr_status;
  - clear every PR with rn_en;
  - then set every PR with wb_en, so writeback wins on a same-PR collision;
  - force bit 0 to 1 if ZERO_PR_READY.
- PR indices ≥ PR_NUM are ignored on every port.
- rd_ready[j] = pr_status[rd_pr_j] OR (any wb_en[k] with wb_pr_k == rd_pr_j). Rename clears in the same cycle do not affect rd_ready. Index ≥ PR_NUM reads 0.
- Checkpoints form a circular FIFO: head = oldest, tail = ckpt_new_id, plus count.
- ckpt_take accepted when !ckpt_full:
  - snap[tail] <= nxt (includes this cycle's rename and writeback);
  - tail++, count++.
  - Take while full is dropped with no state change.
- ckpt_release when !ckpt_empty: head++, count--. Release while empty is ignored.
- Take and release accepted together: count unchanged.
- Every live snapshot ORs in each cycle's writebacks (snap[i][wb_pr] <= 1), so completions of older instructions survive recovery.
- Recovery (recover_en with recover_id live, i.e. within head..tail-1 modulo CKPT_NUM):
  - pr_status <= snap[recover_id] with this cycle's writebacks set;
  - tail <= recover_id+1; count <= (recover_id-head mod CKPT_NUM)+1;
  - renames and take in that cycle are ignored;
  - a same-cycle release still applies (head++, count--).
- recover_en with a non-live id: ignored; the normal update applies.
- flush_all, highest priority: pr_status all ones, head = tail = 0, count = 0. All other inputs that cycle are ignored.

## Timing
- Reset: pr_status all ones, head = tail = 0, ckpt_count 0, ckpt_empty 1, ckpt_full 0, ckpt_new_id 0. Snapshot contents are don't-care.
- pr_status, ckpt_* update one cycle after the inputs. rd_ready is zero-latency.
- Writeback at cycle t: rd_ready high at t via bypass, pr_status bit high at t+1.
- Rename at t: pr_status bit low at t+1.
- Recovery at t: restored vector visible at t+1. A take is accepted again from t+1.
- Reset mid-operation returns all outputs to reset values immediately (asynchronous).
- Priority: rst > flush_all > recover_en > take/rename > release ordering as above.

## Test plan
- Reset, then rename PR 5 and PR 9 at cycle 1 -> pr_status[5] = pr_status[9] = 0 at cycle 2, other bits 1.
- Rename PR 12 at t, wb PR 12 at t+3 with rd_pr_0 = 12 -> rd_ready[0] = 1 at t+3, pr_status[12] = 1 at t+4. Same-cycle rename+wb of PR 20 -> bit 20 = 1.
- Rename PR 30, take checkpoint (id 0), rename PR 31, wb PR 30, recover id 0 -> pr_status[30] = 1, pr_status[31] = 1, count = 1, ckpt_new_id = 1.
- Take 4 checkpoints -> ckpt_full = 1. 5th take dropped, count stays 4. Take+release together -> count 4, head and tail both advance.
- Live ids 1,2,3; recover id 2 -> count = 2, ckpt_new_id = 3. Recover non-live id 0 -> state unchanged except the normal update.
- flush_all with rename PR 40 and recover_en that same cycle -> all ones, count 0. Assert rst mid-burst -> all outputs at reset values immediately. rn_pr = 0 with ZERO_PR_READY -> bit 0 stays 1.
